// File: rtl/cla_share_arb_if.sv
// -----------------------------------------------------------------------------
// cla_share_arb_if
//   Bundles the client-side request/result signals and the adder-side operand
//   and sum signals of the shared carry-lookahead adder arbiter.
//
//   Signals (NREQ requesters, W-bit operands):
//     req      client -> arb   per-requester request
//     a_in     client -> arb   operand A, requester i at [i*W +: W]
//     b_in     client -> arb   operand B, requester i at [i*W +: W]
//     gnt      arb -> client   one-hot grant for the whole op
//     done     arb -> client   one-hot single-cycle result-valid pulse
//     res_sum  arb -> client   captured sum
//     res_cout arb -> client   captured carry-out
//     busy     arb -> client   arbiter not idle
//     add_a    arb -> adder    registered operand A
//     add_b    arb -> adder    registered operand B
//     add_sum  adder -> arb    adder sum
//     add_cout adder -> arb    adder carry-out
//
//   Modports: master = arbiter view, slave = clients plus adder.
// -----------------------------------------------------------------------------
interface cla_share_arb_if #(
   parameter int NREQ = 4,
   parameter int W    = 4
);
   logic [NREQ-1:0]   req;
   logic [NREQ*W-1:0] a_in;
   logic [NREQ*W-1:0] b_in;
   logic [NREQ-1:0]   gnt;
   logic [NREQ-1:0]   done;
   logic [W-1:0]      res_sum;
   logic              res_cout;
   logic              busy;
   logic [W-1:0]      add_a;
   logic [W-1:0]      add_b;
   logic [W-1:0]      add_sum;
   logic              add_cout;

   modport master (
      input  req, a_in, b_in, add_sum, add_cout,
      output gnt, done, res_sum, res_cout, busy, add_a, add_b
   );

   modport slave (
      output req, a_in, b_in, add_sum, add_cout,
      input  gnt, done, res_sum, res_cout, busy, add_a, add_b
   );
endinterface

// File: rtl/cla_share_arb.sv
// -----------------------------------------------------------------------------
// cla_share_arb
//   Round-robin arbiter/sequencer time-sharing one W-bit carry-lookahead adder
//   among NREQ requesters. A winner is granted, its operands are registered
//   onto the adder, the result is captured after ADD_LAT clocks and returned
//   with a one-cycle done pulse. Sequence: IDLE -> WAIT -> DONE -> IDLE.
//
//   Parameters:
//     NREQ     number of requesters (2..8)
//     W        operand width
//     ADD_LAT  adder latency in clocks (0 = combinational, 1 = registered)
//
//   Ports:
//     clk       system clock, rising edge
//     rst       synchronous reset, active-high
//     bus       cla_share_arb_if.master (requests, results, adder operands)
//     op_count  16-bit count of completed ops (only with CLA_ARB_OPCNT_EN)
//
//   Optional feature macro: CLA_ARB_OPCNT_EN adds the op_count output.
// -----------------------------------------------------------------------------
module cla_share_arb #(
   parameter int NREQ    = 4,
   parameter int W       = 4,
   parameter int ADD_LAT = 1
) (
   input  logic            clk,
   input  logic            rst,
`ifdef CLA_ARB_OPCNT_EN
   output logic [15:0]     op_count,
`endif
   cla_share_arb_if.master bus
);

   localparam int PW = $clog2(NREQ);
   localparam int CW = (ADD_LAT > 0) ? $clog2(ADD_LAT + 1) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [PW-1:0]     ptr_q, ptr_d;
   logic [PW-1:0]     owner_q, owner_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [NREQ-1:0]   done_q, done_d;
   logic [W-1:0]      add_a_q, add_a_d;
   logic [W-1:0]      add_b_q, add_b_d;
   logic [W-1:0]      res_sum_q, res_sum_d;
   logic              res_cout_q, res_cout_d;

   logic              win_found;
   logic [PW-1:0]     win_idx;
   logic              cap;

   // Round-robin pick: first set request scanning from ptr upwards, wrapping.
   always_comb begin
      int idx;
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr_q) + k) % NREQ;
         if (!win_found && bus.req[idx]) begin
            win_found = 1'b1;
            win_idx   = PW'(idx);
         end
      end
   end

   // Result capture happens on the last WAIT edge.
   assign cap = (state_q == WAIT) && (cnt_q == '0);

   // NOTE: every signal written here gets a hold/default value first, so no
   // path leaves a variable unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      owner_d    = owner_q;
      cnt_d      = cnt_q;
      gnt_d      = gnt_q;
      done_d     = done_q;
      add_a_d    = add_a_q;
      add_b_d    = add_b_q;
      res_sum_d  = res_sum_q;
      res_cout_d = res_cout_q;

      unique case (state_q)
         IDLE: begin
            if (win_found) begin
               add_a_d          = bus.a_in[win_idx*W +: W];
               add_b_d          = bus.b_in[win_idx*W +: W];
               gnt_d            = '0;
               gnt_d[win_idx]   = 1'b1;
               owner_d          = win_idx;
               ptr_d            = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
               cnt_d            = CW'(ADD_LAT);
               state_d          = WAIT;
            end
         end
         WAIT: begin
            if (!cap) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               res_sum_d        = bus.add_sum;
               res_cout_d       = bus.add_cout;
               done_d           = '0;
               done_d[owner_q]  = 1'b1;
               gnt_d            = '0;
               state_d          = DONE;
            end
         end
         DONE: begin
            // Requests are deliberately not sampled here.
            done_d  = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignment so every flop samples
   // pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         owner_q    <= '0;
         cnt_q      <= '0;
         gnt_q      <= '0;
         done_q     <= '0;
         add_a_q    <= '0;
         add_b_q    <= '0;
         res_sum_q  <= '0;
         res_cout_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         owner_q    <= owner_d;
         cnt_q      <= cnt_d;
         gnt_q      <= gnt_d;
         done_q     <= done_d;
         add_a_q    <= add_a_d;
         add_b_q    <= add_b_d;
         res_sum_q  <= res_sum_d;
         res_cout_q <= res_cout_d;
      end
   end

   assign bus.gnt      = gnt_q;
   assign bus.done     = done_q;
   assign bus.res_sum  = res_sum_q;
   assign bus.res_cout = res_cout_q;
   assign bus.busy     = (state_q != IDLE);
   assign bus.add_a    = add_a_q;
   assign bus.add_b    = add_b_q;

`ifdef CLA_ARB_OPCNT_EN
   // Completed-op counter, bumped on each edge that raises done; wraps freely.
   logic [15:0] op_cnt_q, op_cnt_d;

   always_comb begin
      op_cnt_d = op_cnt_q;
      if (cap) op_cnt_d = op_cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) op_cnt_q <= '0;
      else     op_cnt_q <= op_cnt_d;
   end

   assign op_count = op_cnt_q;
`endif

endmodule

// File: tb/tb_cla_share_arb.sv
// -----------------------------------------------------------------------------
// tb_cla_share_arb
//   Drives two arbiters from the same requests: dut1 with a registered adder
//   (ADD_LAT=1) and dut0 with a combinational adder (ADD_LAT=0). A
//   transaction-level model per DUT predicts every output each cycle; directed
//   sequences add hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_cla_share_arb;

   localparam int NREQ = 4;
   localparam int W    = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NREQ-1:0]   req = '0;
   logic [NREQ*W-1:0] a_in = '0;
   logic [NREQ*W-1:0] b_in = '0;
   bit                chk_en = 1'b0;
   int                checks = 0;
   int                errors = 0;

   always #5 clk = ~clk;

   cla_share_arb_if #(.NREQ(NREQ), .W(W)) if1 ();
   cla_share_arb_if #(.NREQ(NREQ), .W(W)) if0 ();

   assign if1.req  = req;
   assign if1.a_in = a_in;
   assign if1.b_in = b_in;
   assign if0.req  = req;
   assign if0.a_in = a_in;
   assign if0.b_in = b_in;

   // Registered adder for dut1, combinational adder for dut0.
   always @(posedge clk) {if1.add_cout, if1.add_sum} <= {1'b0, if1.add_a} + {1'b0, if1.add_b};
   assign {if0.add_cout, if0.add_sum} = {1'b0, if0.add_a} + {1'b0, if0.add_b};

`ifdef CLA_ARB_OPCNT_EN
   logic [15:0] opc1, opc0;
`endif

   cla_share_arb #(.NREQ(NREQ), .W(W), .ADD_LAT(1)) dut1 (
      .clk      (clk),
      .rst      (rst),
`ifdef CLA_ARB_OPCNT_EN
      .op_count (opc1),
`endif
      .bus      (if1.master)
   );

   cla_share_arb #(.NREQ(NREQ), .W(W), .ADD_LAT(0)) dut0 (
      .clk      (clk),
      .rst      (rst),
`ifdef CLA_ARB_OPCNT_EN
      .op_count (opc0),
`endif
      .bus      (if0.master)
   );

   // ---------------------------------------------------------------- model
   // age counts cycles since the grant edge (0 = idle): grant visible for
   // ages 1..lat+1, done at age lat+2, idle again afterwards.
   typedef struct {
      int           age;
      int           owner;
      int           ptr;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] sum;
      logic         cout;
      logic [15:0]  ops;
   } mdl_t;

   mdl_t m [2];

   function automatic mdl_t step(input mdl_t s, input int lat, input logic r,
                                 input logic [NREQ-1:0] rq,
                                 input logic [NREQ*W-1:0] av,
                                 input logic [NREQ*W-1:0] bv);
      mdl_t n;
      int   w;
      n = s;
      if (r) begin
         n.age = 0; n.owner = 0; n.ptr = 0; n.a = '0; n.b = '0;
         n.sum = '0; n.cout = 1'b0; n.ops = '0;
      end else if (s.age == 0) begin
         if (rq != '0) begin
            w = s.ptr;
            while (!rq[w]) w = (w + 1) % NREQ;
            n.owner = w;
            n.ptr   = (w + 1) % NREQ;
            n.a     = av[w*W +: W];
            n.b     = bv[w*W +: W];
            n.age   = 1;
         end
      end else if (s.age == lat + 1) begin
         {n.cout, n.sum} = {1'b0, s.a} + {1'b0, s.b};
         n.ops = s.ops + 16'd1;
         n.age = lat + 2;
      end else if (s.age == lat + 2) begin
         n.age = 0;
      end else begin
         n.age = s.age + 1;
      end
      return n;
   endfunction

   initial begin
      for (int i = 0; i < 2; i++) m[i] = step(m[i], i, 1'b1, '0, '0, '0);
   end

   always @(posedge clk) begin
      m[0] = step(m[0], 0, rst, req, a_in, b_in);
      m[1] = step(m[1], 1, rst, req, a_in, b_in);
   end

   // ---------------------------------------------------------------- checks
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp(input string t, input int lat, input mdl_t s,
                      input logic [NREQ-1:0] g, input logic [NREQ-1:0] d, input logic bz,
                      input logic [W-1:0] aa, input logic [W-1:0] bb,
                      input logic [W-1:0] rs, input logic rc);
      logic [NREQ-1:0] g_exp;
      logic [NREQ-1:0] d_exp;
      g_exp = (s.age >= 1 && s.age <= lat + 1) ? NREQ'(1 << s.owner) : '0;
      d_exp = (s.age == lat + 2) ? NREQ'(1 << s.owner) : '0;
      check({t, ".gnt"},      32'(g),  32'(g_exp));
      check({t, ".done"},     32'(d),  32'(d_exp));
      check({t, ".busy"},     32'(bz), 32'(s.age != 0));
      check({t, ".add_a"},    32'(aa), 32'(s.a));
      check({t, ".add_b"},    32'(bb), 32'(s.b));
      check({t, ".res_sum"},  32'(rs), 32'(s.sum));
      check({t, ".res_cout"}, 32'(rc), 32'(s.cout));
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp("m1", 1, m[1], if1.gnt, if1.done, if1.busy, if1.add_a, if1.add_b,
             if1.res_sum, if1.res_cout);
         cmp("m0", 0, m[0], if0.gnt, if0.done, if0.busy, if0.add_a, if0.add_b,
             if0.res_sum, if0.res_cout);
`ifdef CLA_ARB_OPCNT_EN
         check("m1.op_count", 32'(opc1), 32'(m[1].ops));
         check("m0.op_count", 32'(opc0), 32'(m[0].ops));
`endif
      end
   end

   // ---------------------------------------------------------------- stimulus
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      req = '0;
      repeat (n) cyc();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   // One isolated op from requester idx; checks dut1 (and dut0 done timing).
   task automatic single_op(input int idx, input int av, input int bv, input string t);
      int s;
      s = av + bv;
      idle(5);
      a_in[idx*W +: W] = W'(av);
      b_in[idx*W +: W] = W'(bv);
      req[idx] = 1'b1;                                    // cycle 0
      cyc(); req = '0; mid();                             // cycle 1
      check({t, ".gnt_c1"},   32'(if1.gnt),   32'(1 << idx));
      check({t, ".add_a_c1"}, 32'(if1.add_a), 32'(av));
      check({t, ".add_b_c1"}, 32'(if1.add_b), 32'(bv));
      cyc(); mid();                                       // cycle 2
      check({t, ".gnt_c2"},   32'(if1.gnt),   32'(1 << idx));
      check({t, ".done0_c2"}, 32'(if0.done),  32'(1 << idx));
      check({t, ".sum0_c2"},  32'(if0.res_sum), 32'(s % 16));
      cyc(); mid();                                       // cycle 3
      check({t, ".done_c3"},  32'(if1.done),  32'(1 << idx));
      check({t, ".gnt_c3"},   32'(if1.gnt),   32'(0));
      check({t, ".sum_c3"},   32'(if1.res_sum),  32'(s % 16));
      check({t, ".cout_c3"},  32'(if1.res_cout), 32'(s / 16));
      cyc(); mid();                                       // cycle 4
      check({t, ".busy_c4"},  32'(if1.busy),  32'(0));
   endtask

   int ta [NREQ] = '{9, 7, 12, 5};
   int tbv[NREQ] = '{8, 3, 6, 14};

   initial begin
      int j;
      // Reset state.
      cyc();
      chk_en = 1'b1;
      rst = 1'b0;
      mid();
      check("rst.gnt",  32'(if1.gnt),  32'(0));
      check("rst.busy", 32'(if1.busy), 32'(0));

      // Basic op and overflow cases.
      single_op(0, 3, 4, "t1");
      single_op(2, 15, 1, "t2a");
      single_op(2, 15, 15, "t2b");

      // All four requesting: grants 0,1,2,3,0 every 4 cycles.
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
         a_in[i*W +: W] = W'(ta[i]);
         b_in[i*W +: W] = W'(tbv[i]);
      end
      req = '1;
      for (int c = 1; c <= 20; c++) begin
         cyc(); mid();
         j = (c - 1) / 4;
         if (c % 4 == 1) check("t3.gnt", 32'(if1.gnt), 32'(1 << (j % 4)));
         if (c % 4 == 3) begin
            check("t3.done", 32'(if1.done), 32'(1 << (j % 4)));
            check("t3.sum",  32'(if1.res_sum),  32'((ta[j % 4] + tbv[j % 4]) % 16));
            check("t3.cout", 32'(if1.res_cout), 32'((ta[j % 4] + tbv[j % 4]) / 16));
         end
      end

      // Requesters 0 and 3: alternate; dut0 finishes one cycle earlier.
      idle(1);
      do_reset();
      req = 4'b1001;
      for (int c = 1; c <= 13; c++) begin
         cyc(); mid();
         if (c % 4 == 1) check("t4.gnt1", 32'(if1.gnt), 32'((((c - 1) / 4) % 2 == 0) ? 1 : 8));
         if (c % 3 == 1) check("t4.gnt0", 32'(if0.gnt), 32'((((c - 1) / 3) % 2 == 0) ? 1 : 8));
         if (c == 2) begin
            check("t4.done0_c2", 32'(if0.done), 32'(1));
            check("t4.done1_c2", 32'(if1.done), 32'(0));
         end
         if (c == 3) check("t4.done1_c3", 32'(if1.done), 32'(1));
      end

      // Reset during WAIT of requester 1.
      idle(6);
      req = 4'b0010;                                      // cycle 0
      cyc(); mid();                                       // cycle 1
      check("t5.gnt_c1", 32'(if1.gnt), 32'(2));
      rst = 1'b1;
      cyc(); rst = 1'b0; req = 4'b1010; mid();            // cycle 2
      check("t5.gnt",  32'(if1.gnt),      32'(0));
      check("t5.done", 32'(if1.done),     32'(0));
      check("t5.busy", 32'(if1.busy),     32'(0));
      check("t5.adda", 32'(if1.add_a),    32'(0));
      check("t5.sum",  32'(if1.res_sum),  32'(0));
      check("t5.cout", 32'(if1.res_cout), 32'(0));
      check("t5.done0", 32'(if0.done),    32'(0));
      cyc(); mid();                                       // cycle 3
      check("t5.regnt",  32'(if1.gnt),  32'(2));
      check("t5.nodone", 32'(if1.done), 32'(0));

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         rst  = ($urandom_range(0, 199) == 0);
         req  = NREQ'($urandom);
         a_in = (NREQ*W)'($urandom);
         b_in = (NREQ*W)'($urandom);
         cyc();
      end
      rst = 1'b0;
      idle(6);

`ifdef CLA_ARB_OPCNT_EN
      // Five ops on dut1, then wrap from 16'hFFFF, then reset.
      do_reset();
      req = 4'b0001;
      for (int c = 1; c <= 20; c++) begin
         cyc();
         if (c == 17) req = '0;
      end
      mid();
      check("t6.five", 32'(opc1), 32'(5));
      idle(4);
      force dut1.op_cnt_q = 16'hFFFF;
      release dut1.op_cnt_q;
      m[1].ops = 16'hFFFF;
      req = 4'b0001;
      cyc(); req = '0;
      repeat (4) cyc();
      mid();
      check("t6.wrap", 32'(opc1), 32'(0));
      req = 4'b0001;
      cyc(); req = '0;
      repeat (4) cyc();
      do_reset();
      mid();
      check("t6.rst", 32'(opc1), 32'(0));
`endif

      idle(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
